// File: rtl/pad_cfg_ret_pkg.sv
// Shared types for the pad config / IO retention controller: per-pad config word, FSM states, reset config.
package pad_cfg_ret_pkg;

  typedef struct packed {
    logic       puen;
    logic [1:0] drv;
    logic       slw;
    logic       smt;
  } pad_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_APPLY,
    ST_FREEZE_IN,
    ST_RET_ASSERT,
    ST_RETAINED,
    ST_RET_RELEASE,
    ST_FREEZE_OUT
  } ctrl_state_e;

  localparam pad_cfg_t PAD_CFG_RST = '{puen: 1'b1, drv: 2'b00, slw: 1'b0, smt: 1'b0};

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_cfg_ret_timer.sv
// Loadable down-counter shared by all timed controller states; done while the count sits at zero.
module pad_cfg_ret_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/pad_cfg_ret_ctrl.sv
// Per-pad config registers with glitch-safe (tristated) updates plus IO retention entry/exit sequencing.
// Optional PAD_CFG_LOCK_EN adds a sticky cfg_lock_i that turns accepted writes into rejected ones.
module pad_cfg_ret_ctrl
  import pad_cfg_ret_pkg::*;
#(
  parameter int unsigned NUM_PADS   = 32,
  parameter int unsigned CFG_SETTLE = 4,
  parameter int unsigned FREEZE_CYC = 8,
  parameter int unsigned RET_CYC    = 16,
  parameter int unsigned IDX_W      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  pad_cfg_t              cfg_data_i,
  output logic                  cfg_err_o,
`ifdef PAD_CFG_LOCK_EN
  input  logic                  cfg_lock_i,
`endif
  input  logic                  ret_req_i,
  output logic                  ret_ack_o,
  output logic                  busy_o,
  input  logic [NUM_PADS-1:0]   core_oen_i,
  output logic [NUM_PADS-1:0]   pad_oen_o,
  output logic [NUM_PADS-1:0]   pad_puen_o,
  output logic [NUM_PADS-1:0]   pad_slw_o,
  output logic [NUM_PADS-1:0]   pad_smt_o,
  output logic [2*NUM_PADS-1:0] pad_drv_o,
  output logic                  pad_retc_o
);

  localparam int unsigned CNT_W = max_of(1, $clog2(max_of(max_of(CFG_SETTLE, FREEZE_CYC), RET_CYC)));
  localparam logic [NUM_PADS-1:0] PAD_ONE = NUM_PADS'(1);

  ctrl_state_e         state_q, state_d;
  pad_cfg_t            cfg_q [NUM_PADS];
  logic [NUM_PADS-1:0] frz_mask_q, frz_mask_d;
  logic                err_q, err_d;
  logic                cfg_we;
  logic                tmr_load, tmr_done;
  logic [CNT_W-1:0]    tmr_val, tmr_value;
  logic                idx_ok, lock_blk;

  assign idx_ok = ({1'b0, cfg_idx_i} < (IDX_W+1)'(NUM_PADS));

`ifdef PAD_CFG_LOCK_EN
  logic locked_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked_q <= 1'b0;
    end else if (cfg_lock_i) begin
      locked_q <= 1'b1;
    end
  end
  assign lock_blk = locked_q;
`else
  assign lock_blk = 1'b0;
`endif

  pad_cfg_ret_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    frz_mask_d = frz_mask_q;
    err_d      = 1'b0;
    cfg_we     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Retention wins over a write offered in the same cycle (ready is low).
        if (ret_req_i) begin
          state_d    = ST_FREEZE_IN;
          frz_mask_d = '1;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(FREEZE_CYC - 1);
        end else if (cfg_valid_i) begin
          if (idx_ok && !lock_blk) begin
            cfg_we     = 1'b1;
            frz_mask_d = frz_mask_q | (PAD_ONE << cfg_idx_i);
            state_d    = ST_CFG_APPLY;
            tmr_load   = 1'b1;
            tmr_val    = CNT_W'(CFG_SETTLE - 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CFG_APPLY: if (tmr_done) begin
        state_d    = ST_IDLE;
        frz_mask_d = '0;
      end
      ST_FREEZE_IN: if (tmr_done) begin
        state_d  = ST_RET_ASSERT;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(RET_CYC - 1);
      end
      ST_RET_ASSERT: if (tmr_done) begin
        state_d = ST_RETAINED;
      end
      ST_RETAINED: if (!ret_req_i) begin
        state_d  = ST_RET_RELEASE;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(RET_CYC - 1);
      end
      ST_RET_RELEASE: if (tmr_done) begin
        state_d  = ST_FREEZE_OUT;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(FREEZE_CYC - 1);
      end
      ST_FREEZE_OUT: if (tmr_done) begin
        state_d    = ST_IDLE;
        frz_mask_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      frz_mask_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= PAD_CFG_RST;
    end else begin
      state_q    <= state_d;
      frz_mask_q <= frz_mask_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_PADS; i++) begin
        if (cfg_we && (cfg_idx_i == IDX_W'(i))) cfg_q[i] <= cfg_data_i;
      end
    end
  end

  always_comb begin
    pad_puen_o = '0;
    pad_slw_o  = '0;
    pad_smt_o  = '0;
    pad_drv_o  = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      pad_puen_o[i]      = cfg_q[i].puen;
      pad_slw_o[i]       = cfg_q[i].slw;
      pad_smt_o[i]       = cfg_q[i].smt;
      pad_drv_o[2*i +: 2] = cfg_q[i].drv;
    end
  end

  assign cfg_ready_o = (state_q == ST_IDLE) && !ret_req_i;
  assign cfg_err_o   = err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign ret_ack_o   = (state_q == ST_RETAINED);
  assign pad_retc_o  = (state_q == ST_RET_ASSERT) || (state_q == ST_RETAINED);
  assign pad_oen_o   = core_oen_i | frz_mask_q;

endmodule

// File: tb/tb_pad_cfg_ret_ctrl.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle they are due; a negedge monitor checks them.
module tb_pad_cfg_ret_ctrl;
  import pad_cfg_ret_pkg::*;

  localparam int unsigned NP = 30;
  localparam logic [63:0] CORE = 64'h15A5_A5A5;
  localparam logic [63:0] ALL1 = 64'h3FFF_FFFF;
  localparam int S_BUSY = 0, S_RETC = 1, S_ACK = 2, S_ERR = 3, S_RDY = 4;
  localparam int S_OEN = 5, S_PUEN = 6, S_DRV = 7, S_SLW = 8, S_SMT = 9;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       nm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_ready, cfg_err, ret_req, ret_ack, busy, retc;
  logic [4:0]    cfg_idx;
  logic [4:0]    cfg_data;
  logic [NP-1:0] core_oen, pad_oen, puen, slw, smt;
  logic [2*NP-1:0] drv;
`ifdef PAD_CFG_LOCK_EN
  logic          cfg_lock;
`endif

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] act;

  pad_cfg_ret_ctrl #(.NUM_PADS(NP), .CFG_SETTLE(4), .FREEZE_CYC(8), .RET_CYC(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_data_i  (cfg_data),
    .cfg_err_o   (cfg_err),
`ifdef PAD_CFG_LOCK_EN
    .cfg_lock_i  (cfg_lock),
`endif
    .ret_req_i   (ret_req),
    .ret_ack_o   (ret_ack),
    .busy_o      (busy),
    .core_oen_i  (core_oen),
    .pad_oen_o   (pad_oen),
    .pad_puen_o  (puen),
    .pad_slw_o   (slw),
    .pad_smt_o   (smt),
    .pad_drv_o   (drv),
    .pad_retc_o  (retc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(input int sel);
    case (sel)
      S_BUSY:  return 64'(busy);
      S_RETC:  return 64'(retc);
      S_ACK:   return 64'(ret_ack);
      S_ERR:   return 64'(cfg_err);
      S_RDY:   return 64'(cfg_ready);
      S_OEN:   return 64'(pad_oen);
      S_PUEN:  return 64'(puen);
      S_DRV:   return 64'(drv);
      S_SLW:   return 64'(slw);
      default: return 64'(smt);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        act = sample(sb[i].sel);
        checks++;
        if (sb[i].cyc != cyc || act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", sb[i].nm, cyc, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int dc, input int sel, input logic [63:0] val, input string nm);
    sb.push_back('{cyc + dc, sel, val, nm});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_idx = '0; cfg_data = '0; ret_req = 1'b0;
    core_oen = CORE[NP-1:0];
`ifdef PAD_CFG_LOCK_EN
    cfg_lock = 1'b0;
`endif
    step(3);
    exp_at(0, S_BUSY, 0, "rst_busy");   exp_at(0, S_RETC, 0, "rst_retc");
    exp_at(0, S_ACK, 0, "rst_ack");     exp_at(0, S_ERR, 0, "rst_err");
    exp_at(0, S_RDY, 1, "rst_rdy");     exp_at(0, S_OEN, CORE, "rst_oen");
    exp_at(0, S_PUEN, ALL1, "rst_puen"); exp_at(0, S_DRV, 0, "rst_drv");
    exp_at(0, S_SLW, 0, "rst_slw");     exp_at(0, S_SMT, 0, "rst_smt");
    rst = 1'b0;
    step(2);

    // pad3 <- {puen=0, drv=3, slw=1, smt=1}
    cfg_valid = 1'b1; cfg_idx = 5'd3; cfg_data = 5'b0_11_1_1;
    exp_at(0, S_RDY, 1, "wr_rdy");
    exp_at(1, S_PUEN, ALL1 & ~64'h8, "wr_puen"); exp_at(1, S_DRV, 64'hC0, "wr_drv");
    exp_at(1, S_SLW, 64'h8, "wr_slw");          exp_at(1, S_SMT, 64'h8, "wr_smt");
    exp_at(1, S_OEN, CORE | 64'h8, "wr_oen_first"); exp_at(1, S_BUSY, 1, "wr_busy");
    exp_at(1, S_RDY, 0, "wr_rdy_apply");
    exp_at(4, S_OEN, CORE | 64'h8, "wr_oen_last"); exp_at(5, S_OEN, CORE, "wr_oen_clr");
    exp_at(4, S_BUSY, 1, "wr_busy_last");          exp_at(5, S_BUSY, 0, "wr_idle");
    step(1); cfg_valid = 1'b0;
    step(6);

    // index 31 is beyond NUM_PADS=30
    cfg_valid = 1'b1; cfg_idx = 5'd31; cfg_data = 5'b1_11_1_1;
    exp_at(0, S_ERR, 0, "oor_err_pre"); exp_at(1, S_ERR, 1, "oor_err");
    exp_at(2, S_ERR, 0, "oor_err_end"); exp_at(1, S_BUSY, 0, "oor_busy");
    exp_at(2, S_DRV, 64'hC0, "oor_drv"); exp_at(2, S_PUEN, ALL1 & ~64'h8, "oor_puen");
    step(1); cfg_valid = 1'b0;
    step(3);

    // retention request with a competing write in the same cycle
    ret_req = 1'b1; cfg_valid = 1'b1; cfg_idx = 5'd5; cfg_data = 5'b0_00_0_0;
    exp_at(0, S_RDY, 0, "ret_rdy");     exp_at(1, S_OEN, ALL1, "frz_oen");
    exp_at(1, S_BUSY, 1, "frz_busy");   exp_at(8, S_RETC, 0, "retc_pre");
    exp_at(9, S_RETC, 1, "retc_rise");  exp_at(24, S_ACK, 0, "ack_pre");
    exp_at(25, S_ACK, 1, "ack_rise");   exp_at(25, S_RETC, 1, "ret_retc");
    exp_at(25, S_PUEN, ALL1 & ~64'h8, "ret_puen");
    step(1); cfg_valid = 1'b0;
    step(26);
    ret_req = 1'b0;
    exp_at(0, S_ACK, 1, "ack_hold");     exp_at(1, S_ACK, 0, "ack_fall");
    exp_at(1, S_RETC, 0, "retc_fall");   exp_at(1, S_OEN, ALL1, "rel_oen");
    exp_at(24, S_OEN, ALL1, "unfrz_pre"); exp_at(25, S_OEN, CORE, "unfrz_oen");
    exp_at(25, S_BUSY, 0, "exit_idle");  exp_at(25, S_DRV, 64'hC0, "exit_drv");
    exp_at(25, S_SLW, 64'h8, "exit_slw");
    step(27);

    // request dropped during FREEZE_IN: sequence still reaches RETAINED for one cycle
    ret_req = 1'b1;
    exp_at(25, S_ACK, 1, "drop_ack");   exp_at(26, S_ACK, 0, "drop_ack_fall");
    exp_at(26, S_RETC, 0, "drop_retc"); exp_at(49, S_BUSY, 1, "drop_busy");
    exp_at(50, S_BUSY, 0, "drop_idle");
    step(2); ret_req = 1'b0;
    step(50);

    // reset while RETC is asserted
    ret_req = 1'b1;
    exp_at(12, S_RETC, 1, "mid_retc");
    step(12);
    rst = 1'b1; ret_req = 1'b0;
    exp_at(1, S_RETC, 0, "mrst_retc"); exp_at(1, S_OEN, CORE, "mrst_oen");
    exp_at(1, S_BUSY, 0, "mrst_busy"); exp_at(1, S_PUEN, ALL1, "mrst_puen");
    exp_at(1, S_DRV, 0, "mrst_drv");   exp_at(1, S_SLW, 0, "mrst_slw");
    step(1); rst = 1'b0;
    step(2);

    // highest pad index
    cfg_valid = 1'b1; cfg_idx = 5'd29; cfg_data = 5'b1_01_0_0;
    exp_at(1, S_DRV, 64'h0400_0000_0000_0000, "top_drv");
    exp_at(1, S_OEN, CORE | 64'h2000_0000, "top_oen");
    exp_at(1, S_ERR, 0, "top_err"); exp_at(5, S_OEN, CORE, "top_oen_clr");
    step(1); cfg_valid = 1'b0;
    step(6);

`ifdef PAD_CFG_LOCK_EN
    cfg_lock = 1'b1;
    step(1);
    cfg_lock = 1'b0; cfg_valid = 1'b1; cfg_idx = 5'd0; cfg_data = 5'b0_10_1_0;
    exp_at(0, S_RDY, 1, "lock_rdy");   exp_at(1, S_ERR, 1, "lock_err");
    exp_at(1, S_BUSY, 0, "lock_busy"); exp_at(1, S_PUEN, ALL1, "lock_puen");
    exp_at(1, S_DRV, 64'h0400_0000_0000_0000, "lock_drv"); exp_at(2, S_ERR, 0, "lock_err_end");
    step(1); cfg_valid = 1'b0;
    step(4);
`endif

    step(3);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL end_busy got=%b exp=0", busy);
    end
    checks++;
    if (retc !== 1'b0) begin
      failures++;
      $display("FAIL end_retc got=%b exp=0", retc);
    end
    checks++;
    if (ret_ack !== 1'b0) begin
      failures++;
      $display("FAIL end_ack got=%b exp=0", ret_ack);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL end_err got=%b exp=0", cfg_err);
    end
    checks++;
    if (pad_oen !== core_oen) begin
      failures++;
      $display("FAIL end_oen got=%h exp=%h", pad_oen, core_oen);
    end
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never_checked due=%0d", sb[i].nm, sb[i].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
